// File: rtl/fab_uart_pkg.sv
// Shared definitions for the fabric UART blocks (receiver now, transmitter later).
package fab_uart_pkg;

    localparam int UART_DATA_BITS            = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

endpackage

// File: rtl/fab_uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; reset value selectable.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fab_uart_rx.sv
// Fabric-side 8N1 UART receiver; bytes are presented on a valid/ready holding register.
//
// state | meaning
// IDLE  | line idle, watching for a 1->0 edge on rxs
// START | waiting for the start-bit centre to confirm it is still low
// DATA  | sampling the eight data bits at their centres, LSB first
// STOP  | waiting for the stop-bit centre; deliver, drop (overrun) or flag framing error
// BREAK | line held low after a framing error; wait for it to return high
module fab_uart_rx
    import fab_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      RXD,
    output logic [UART_DATA_BITS-1:0] RX_DATA,
    output logic                      RX_VALID,
    input  logic                      RX_READY,
    output logic                      FRAME_ERR,
    output logic                      OVERRUN
);

    localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic rxs;
    logic rxs_prev;
    logic rxs_fell;

    uart_rx_state_t              state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [2:0]                  idx_q, idx_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [UART_DATA_BITS-1:0]   data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        ferr_q, ferr_d;
    logic                        ovr_q, ovr_d;
    logic                        cnt_zero;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk   (CLK),
        .reset (RESET),
        .d     (RXD),
        .q     (rxs)
    );

    assign rxs_fell = rxs_prev & ~rxs;
    assign cnt_zero = (cnt_q == '0);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxs_prev <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            rxs_prev <= rxs;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q & ~RX_READY;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxs_fell) begin
                    cnt_d   = HALF_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d   = FULL_LOAD;
                        idx_d   = '0;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shift_d[idx_q] = rxs;
                    cnt_d          = FULL_LOAD;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (!rxs) begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end else begin
                        // An acceptance in this same cycle frees the register for the new byte.
                        if (!valid_q || RX_READY) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                        state_d = IDLE;
                    end
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign RX_DATA   = data_q;
    assign RX_VALID  = valid_q;
    assign FRAME_ERR = ferr_q;
    assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_fab_uart_rx.sv
// Directed and randomized checks of fab_uart_rx against a frame-level reference model.
module tb_fab_uart_rx;

    localparam int CPB     = 8;
    localparam int LATENCY = 2 + 1 + CPB / 2 + 9 * CPB;
    localparam int NRAND   = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int ntotal = 0;
    int npass  = 0;
    int nfail  = 0;

    int         cyc = 0;
    int         start_cyc;
    int         rise_cyc;
    int         nrise;
    int         nvalid_cyc;
    int         nerr;
    int         novr;
    int         nunstable;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    int         exp_err;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    fab_uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .RXD       (rxd),
        .RX_DATA   (rx_data),
        .RX_VALID  (rx_valid),
        .RX_READY  (rx_ready),
        .FRAME_ERR (frame_err),
        .OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe outputs mid-cycle, when inputs for the next edge are settled.
    always @(negedge clk) begin
        if (rx_valid && !prev_valid) begin
            rise_cyc = cyc;
            nrise++;
        end
        if (rx_valid) nvalid_cyc++;
        if (rx_valid && rx_ready) got.push_back(rx_data);
        if (frame_err) nerr++;
        if (overrun) novr++;
        if (prev_valid && !prev_ready && rx_valid && (rx_data !== prev_data)) nunstable++;
        prev_valid = rx_valid;
        prev_ready = rx_ready;
        prev_data  = rx_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntotal++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got.delete();
        exp_q.delete();
        exp_err    = 0;
        nrise      = 0;
        nvalid_cyc = 0;
        nerr       = 0;
        novr       = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        start_cyc = cyc;
        rxd = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(CPB);
        end
        rxd = stop_bit;
        wait_cyc(CPB);
    endtask

    task automatic check_queue(input string tag);
        logic [31:0] obs;
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got.size()) ? {24'h0, got[i]} : 32'hxxxxxxxx;
            check($sformatf("%s_byte%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       good;
        nunstable = 0;
        clear_obs();
        reset    = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        wait_cyc(4);
        check("reset_data", rx_data, 8'h00);
        check("reset_valid", rx_valid, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_ovr", overrun, 1'b0);
        reset = 1'b0;
        wait_cyc(CPB);

        // Single byte with the consumer always ready.
        clear_obs();
        send_byte(8'hA5, 1'b1);
        wait_cyc(2 * CPB);
        exp_q.push_back(8'hA5);
        check_queue("a5");
        check("a5_latency", rise_cyc - start_cyc, LATENCY);
        check("a5_valid_cycles", nvalid_cyc, 1);
        check("a5_ferr", nerr, 0);
        check("a5_ovr", novr, 0);

        // Short low glitch must be rejected at the start-bit centre.
        clear_obs();
        rxd = 1'b0;
        wait_cyc(3);
        rxd = 1'b1;
        wait_cyc(3 * CPB);
        check("glitch_valid", nrise, 0);
        check("glitch_ferr", nerr, 0);
        check("glitch_ovr", novr, 0);

        // Framing error, line held low, then a good byte.
        clear_obs();
        send_byte(8'h3C, 1'b0);
        wait_cyc(20);
        rxd = 1'b1;
        wait_cyc(2 * CPB);
        send_byte(8'h5A, 1'b1);
        wait_cyc(2 * CPB);
        exp_q.push_back(8'h5A);
        check_queue("ferr");
        check("ferr_count", nerr, 1);
        check("ferr_ovr", novr, 0);

        // Randomized frames with occasional bad stop bits; the model keeps only good bytes.
        clear_obs();
        for (int f = 0; f < NRAND; f++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            send_byte(b, good);
            if (good) begin
                exp_q.push_back(b);
                wait_cyc($urandom_range(0, 3));
            end else begin
                exp_err++;
                wait_cyc($urandom_range(0, 10));
                rxd = 1'b1;
                wait_cyc(CPB);
            end
        end
        wait_cyc(2 * CPB);
        check_queue("rand");
        check("rand_ferr", nerr, exp_err);
        check("rand_ovr", novr, 0);

        // Overrun: consumer stalled across two back-to-back frames.
        clear_obs();
        rx_ready = 1'b0;
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        wait_cyc(2 * CPB);
        check("ovr_valid", rx_valid, 1'b1);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_count", novr, 1);
        check("ovr_ferr", nerr, 0);
        check("ovr_none_taken", got.size(), 0);
        rx_ready = 1'b1;
        wait_cyc(1);
        rx_ready = 1'b0;
        check("ovr_valid_drop", rx_valid, 1'b0);
        exp_q.push_back(8'h11);
        check_queue("ovr");

        // Acceptance in the same cycle a new byte completes.
        clear_obs();
        send_byte(8'h44, 1'b1);
        wait_cyc(CPB);
        fork
            send_byte(8'h33, 1'b1);
            begin
                wait_cyc(LATENCY - 1);
                rx_ready = 1'b1;
                wait_cyc(1);
                rx_ready = 1'b0;
            end
        join
        wait_cyc(CPB);
        exp_q.push_back(8'h44);
        check_queue("simul");
        check("simul_valid", rx_valid, 1'b1);
        check("simul_data", rx_data, 8'h33);
        check("simul_ovr", novr, 0);

        // Reset in the middle of a frame while a byte is still pending.
        clear_obs();
        fork
            send_byte(8'hF0, 1'b1);
            begin
                wait_cyc(5 * CPB + 2);
                reset = 1'b1;
                wait_cyc(1);
                check("mid_reset_data", rx_data, 8'h00);
                check("mid_reset_valid", rx_valid, 1'b0);
                check("mid_reset_ferr", frame_err, 1'b0);
                check("mid_reset_ovr", overrun, 1'b0);
                wait_cyc(2);
                reset = 1'b0;
            end
        join
        wait_cyc(CPB);
        send_byte(8'h0F, 1'b1);
        wait_cyc(2 * CPB);
        check("post_reset_valid", rx_valid, 1'b1);
        check("post_reset_data", rx_data, 8'h0F);
        rx_ready = 1'b1;
        wait_cyc(2);
        exp_q.push_back(8'h0F);
        check_queue("post_reset");
        check("post_reset_ferr", nerr, 0);
        check("post_reset_ovr", novr, 0);
        check("data_stable", nunstable, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
